// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable tick generator.
// Each channel counts 0..top and emits a registered one-cycle tick on wrap.
// Period updates made while running go through a shadow register and take
// effect at the next wrap, so no runt or stretched period is ever produced.
// Optional feature macro: TICK_GEN_SQUARE_EN (per-channel square-wave on sq).
module tick_gen #(
    parameter int NCH      = 2,
    parameter int WIDTH    = 24,
    parameter int TOP_INIT = 12000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   load,
    input  logic [WIDTH-1:0] top_in,
    input  logic             sync,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq,
    output logic [NCH-1:0]   pend
);

    localparam logic [WIDTH-1:0] TOP_RST = WIDTH'(TOP_INIT);

    // Per-channel operating mode for the current edge; sync outranks en.
    typedef enum logic [1:0] {
        MODE_SYNC,
        MODE_RUN,
        MODE_HOLD
    } mode_t;

    mode_t            mode   [NCH];
    logic [WIDTH-1:0] cnt_q  [NCH];
    logic [WIDTH-1:0] cnt_d  [NCH];
    logic [WIDTH-1:0] top_q  [NCH];
    logic [WIDTH-1:0] top_d  [NCH];
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   wrap;
`ifdef TICK_GEN_SQUARE_EN
    logic [NCH-1:0]   sq_q, sq_d;
`endif

    // Next-state computation for every channel: mode decode, wrap, period update.
    always_comb begin
        tick_d = '0;
        pend_d = pend_q;
        wrap   = '0;
`ifdef TICK_GEN_SQUARE_EN
        sq_d   = sq_q;
`endif
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            top_d[i]    = top_q[i];
            shadow_d[i] = shadow_q[i];
            wrap[i]     = (cnt_q[i] == top_q[i]);
            if (sync)
                mode[i] = MODE_SYNC;
            else if (en[i])
                mode[i] = MODE_RUN;
            else
                mode[i] = MODE_HOLD;

            unique case (mode[i])
                MODE_SYNC: begin
                    cnt_d[i] = '0;
`ifdef TICK_GEN_SQUARE_EN
                    sq_d[i]  = 1'b0;
`endif
                    // A same-edge load beats any older pending shadow.
                    if (load[i]) begin
                        top_d[i]  = top_in;
                        pend_d[i] = 1'b0;
                    end else if (pend_q[i]) begin
                        top_d[i]  = shadow_q[i];
                        pend_d[i] = 1'b0;
                    end
                end
                MODE_RUN: begin
                    if (wrap[i]) begin
                        cnt_d[i]  = '0;
                        tick_d[i] = 1'b1;
`ifdef TICK_GEN_SQUARE_EN
                        sq_d[i]   = ~sq_q[i];
`endif
                        // Load coinciding with wrap bypasses the shadow.
                        if (load[i]) begin
                            top_d[i]  = top_in;
                            pend_d[i] = 1'b0;
                        end else if (pend_q[i]) begin
                            top_d[i]  = shadow_q[i];
                            pend_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        if (load[i]) begin
                            shadow_d[i] = top_in;
                            pend_d[i]   = 1'b1;
                        end
                    end
                end
                default: begin
                    // HOLD: phase frozen; a load restarts the channel on the new top.
                    if (load[i]) begin
                        top_d[i]  = top_in;
                        cnt_d[i]  = '0;
                        pend_d[i] = 1'b0;
                    end
                end
            endcase
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                top_q[i]    <= TOP_RST;
                shadow_q[i] <= TOP_RST;
            end
            pend_q <= '0;
            tick_q <= '0;
`ifdef TICK_GEN_SQUARE_EN
            sq_q   <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                top_q[i]    <= top_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            pend_q <= pend_d;
            tick_q <= tick_d;
`ifdef TICK_GEN_SQUARE_EN
            sq_q   <= sq_d;
`endif
        end
    end

    assign tick = tick_q;
    assign pend = pend_q;
`ifdef TICK_GEN_SQUARE_EN
    assign sq   = sq_q;
`else
    assign sq   = '0;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: a stimulus process drives directed and
// random inputs, advances a reference model and queues the expected
// {tick, sq, pend}; a monitor pops and compares after each rising edge.
module tb_tick_gen;

    localparam int NCH      = 2;
    localparam int WIDTH    = 8;
    localparam int TOP_INIT = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   en = '0;
    logic [NCH-1:0]   load = '0;
    logic [WIDTH-1:0] top_in = '0;
    logic             sync = 1'b0;
    logic [NCH-1:0]   tick, sq, pend;

    tick_gen #(.NCH(NCH), .WIDTH(WIDTH), .TOP_INIT(TOP_INIT)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .load   (load),
        .top_in (top_in),
        .sync   (sync),
        .tick   (tick),
        .sq     (sq),
        .pend   (pend)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
        logic [NCH-1:0] pend;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    // Reference model: position within period, period length, queued period.
    int m_pos    [NCH];
    int m_top    [NCH];
    int m_next   [NCH];
    bit m_has_next [NCH];
    bit m_tick   [NCH];
    bit m_sq     [NCH];

    function automatic void model_edge(bit r, bit s, bit [NCH-1:0] e,
                                       bit [NCH-1:0] l, int t);
        for (int c = 0; c < NCH; c++) begin
            m_tick[c] = 0;
            if (r) begin
                m_pos[c] = 0; m_top[c] = TOP_INIT; m_next[c] = TOP_INIT;
                m_has_next[c] = 0; m_sq[c] = 0;
            end else if (s) begin
                m_pos[c] = 0; m_sq[c] = 0;
                if (l[c]) m_top[c] = t;
                else if (m_has_next[c]) m_top[c] = m_next[c];
                m_has_next[c] = 0;
            end else if (!e[c]) begin
                if (l[c]) begin
                    m_top[c] = t; m_pos[c] = 0; m_has_next[c] = 0;
                end
            end else if (m_pos[c] == m_top[c]) begin
                m_pos[c] = 0; m_tick[c] = 1; m_sq[c] = !m_sq[c];
                if (l[c]) m_top[c] = t;
                else if (m_has_next[c]) m_top[c] = m_next[c];
                m_has_next[c] = 0;
            end else begin
                m_pos[c] = m_pos[c] + 1;
                if (l[c]) begin
                    m_next[c] = t; m_has_next[c] = 1;
                end
            end
        end
    endfunction

    // Apply inputs for the next rising edge and queue what that edge must produce.
    task automatic drive(bit r, bit s, bit [NCH-1:0] e, bit [NCH-1:0] l, int t);
        obs_t o;
        @(negedge clk);
        reset = r; sync = s; en = e; load = l; top_in = WIDTH'(t);
        model_edge(r, s, e, l, t);
        for (int c = 0; c < NCH; c++) begin
            o.tick[c] = m_tick[c];
            o.pend[c] = m_has_next[c];
`ifdef TICK_GEN_SQUARE_EN
            o.sq[c]   = m_sq[c];
`else
            o.sq[c]   = 1'b0;
`endif
        end
        exp_q.push_back(o);
    endtask

    task automatic idle(int n, bit [NCH-1:0] e);
        for (int k = 0; k < n; k++) drive(0, 0, e, '0, 0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        obs_t want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if (tick !== want.tick || sq !== want.sq || pend !== want.pend) begin
                    errors++;
                    $display("FAIL outputs t=%0t: tick/sq/pend got %b/%b/%b expected %b/%b/%b",
                             $time, tick, sq, pend, want.tick, want.sq, want.pend);
                end
            end
        end
    end

    initial begin
        bit [NCH-1:0] e_cur;
        bit [NCH-1:0] l_cur;
        bit           r_cur, s_cur;
        int           t_cur;

        // Reset, then channel 0 running from TOP_INIT=3.
        drive(1, 0, '0, '0, 0);
        drive(1, 0, '0, '0, 0);
        idle(14, 2'b01);

        // Period update while running: two loads before the wrap, last wins.
        drive(1, 0, '0, '0, 0);
        drive(0, 0, 2'b01, '0, 0);
        drive(0, 0, 2'b01, 2'b01, 7);
        drive(0, 0, 2'b01, 2'b01, 9);
        idle(35, 2'b01);

        // Channel 1 top=12 loaded in HOLD, frozen at cnt=5 for 20 cycles.
        drive(0, 0, 2'b01, 2'b10, 12);
        idle(5, 2'b11);
        idle(20, 2'b01);
        idle(20, 2'b11);

        // Tops 4 and 6, sync mid-count.
        drive(0, 0, 2'b00, 2'b11, 4);
        drive(0, 0, 2'b00, 2'b10, 6);
        idle(9, 2'b11);
        drive(0, 1, 2'b11, '0, 0);
        idle(16, 2'b11);

        // Load on sync edge, and sync while a shadow is pending.
        drive(0, 0, 2'b11, 2'b01, 2);
        drive(0, 1, 2'b11, 2'b10, 3);
        idle(10, 2'b11);

        // top=0: tick every cycle, sq toggles every cycle.
        drive(0, 0, 2'b00, 2'b01, 0);
        idle(8, 2'b11);

        // Load coinciding with a wrap on top=0.
        drive(0, 0, 2'b11, 2'b01, 5);
        idle(8, 2'b11);

        // Reset overrides simultaneous load, sync and en.
        drive(1, 1, 2'b11, 2'b11, 9);
        idle(10, 2'b11);

        // Randomized phase.
        e_cur = 2'b11;
        for (int k = 0; k < 4000; k++) begin
            r_cur = ($urandom_range(0, 299) == 0);
            s_cur = ($urandom_range(0, 79) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 24) == 0) e_cur[c] = !e_cur[c];
                l_cur[c] = ($urandom_range(0, 14) == 0);
            end
            t_cur = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 255)
                                                 : $urandom_range(0, 12);
            drive(r_cur, s_cur, e_cur, l_cur, t_cur);
        end

        idle(1, '0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: queue holds %0d entries, expected 0", exp_q.size());
        end
        stim_done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
